// File: rtl/menu_pkg.sv
// Shared types, button indices and value-step helper for the menu controller.
package menu_pkg;

  // Controller states
  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    IDLE   = 2'd1,
    HOLD   = 2'd2
  } menu_state_e;

  // Single action chosen per frame after priority resolution
  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_MENU = 3'd1,
    ACT_UP   = 3'd2,
    ACT_DOWN = 3'd3,
    ACT_INC  = 3'd4,
    ACT_DEC  = 3'd5
  } menu_act_e;

  // Button indices; lower index wins when several events fire in one frame
  localparam int B_MENU = 0;
  localparam int B_UP   = 1;
  localparam int B_DOWN = 2;
  localparam int B_INC  = 3;
  localparam int B_DEC  = 4;
  localparam int N_BTN  = 5;

  // One inc/dec step with 9-bit arithmetic, wrapping or saturating at the bounds
  function automatic logic [7:0] step_val(input logic [7:0] cur, input logic up,
                                          input logic [7:0] vmin, input logic [7:0] vmax,
                                          input logic wrap);
    logic [8:0] t;
    logic [7:0] r;
    if (up) begin
      t = {1'b0, cur} + 9'd1;
      if (t > {1'b0, vmax}) r = wrap ? vmin : vmax;
      else                  r = t[7:0];
    end else begin
      t = {1'b0, cur} - 9'd1;
      if (t[8] || (t[7:0] < vmin)) r = wrap ? vmax : vmin;
      else                         r = t[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/menu_ctrl_frame_debounce.sv
// Per-button synchroniser plus two-frame history; flags a debounced rising edge.
module frame_debounce (
  input  logic clk,
  input  logic rst,
  input  logic newframe,
  input  logic btn,
  output logic level_next,
  output logic press
);

  logic [1:0] btn_sync_r;
  logic [1:0] hist_r;

  // Two-flop synchroniser every clock; history shifts only on frame boundaries
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_sync_r <= 2'b00;
      hist_r     <= 2'b00;
    end else begin
      btn_sync_r <= {btn_sync_r[0], btn};
      if (newframe) hist_r <= {hist_r[0], btn_sync_r[1]};
      else          hist_r <= hist_r;
    end
  end

  // Debounced level as it becomes after this frame's sample (meaningful in newframe cycles)
  assign level_next = hist_r[0] & btn_sync_r[1];
  // Rising edge of the debounced level, reported in the frame it happens
  assign press      = newframe & level_next & ~(&hist_r);

endmodule

// File: rtl/menu_ctrl.sv
// Menu navigation controller: debounced buttons, visibility FSM, item values and read port.
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int         N_ITEMS      = 2,
  parameter logic [7:0] INIT_VAL     = 8'h00,
  parameter logic [7:0] VAL_MIN      = 8'h00,
  parameter logic [7:0] VAL_MAX      = 8'hFF,
  parameter bit         WRAP         = 1'b1,
  parameter int         REPEAT_DELAY = 30,
  parameter int         REPEAT_RATE  = 4,
  localparam int        IW           = $clog2(N_ITEMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newframe,
  input  logic                 btn_menu,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_inc,
  input  logic                 btn_dec,
  input  logic [IW-1:0]        rd_idx,
  output logic [7:0]           rd_val,
  output logic                 rd_hl,
  output logic                 menu_visible,
  output logic [IW-1:0]        sel_item,
  output logic [8*N_ITEMS-1:0] values,
  output logic                 cfg_strobe,
  output logic [IW-1:0]        cfg_idx
);

  localparam logic [7:0] DELAY_L = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_L  = 8'(REPEAT_RATE);

  logic [N_BTN-1:0] btn_raw_s, lvl_s, press_s;
  menu_state_e      state_r;
  menu_act_e        act_s;
  logic             visible_r, cfg_strobe_r;
  logic [IW-1:0]    sel_r, cfg_idx_r, sel_prev_s, sel_next_s;
  logic [7:0]       rep_r;
  logic [N_BTN-1:0] hold_btn_r;
  logic [7:0]       val_r [N_ITEMS];
  logic [7:0]       cur_val_s, nv_s, rd_val_s;
  logic             nv_chg_s, dir_up_s, hold_lvl_s, rd_hl_s;

  // Bit positions follow the B_* indices
  assign btn_raw_s = {btn_dec, btn_inc, btn_down, btn_up, btn_menu};

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    frame_debounce u_deb (
      .clk        (clk),
      .rst        (rst),
      .newframe   (newframe),
      .btn        (btn_raw_s[g]),
      .level_next (lvl_s[g]),
      .press      (press_s[g])
    );
  end

  // Resolve this frame's events to one action, highest priority first
  always_comb begin
    act_s = ACT_NONE;
    if      (press_s[B_MENU]) act_s = ACT_MENU;
    else if (press_s[B_UP])   act_s = ACT_UP;
    else if (press_s[B_DOWN]) act_s = ACT_DOWN;
    else if (press_s[B_INC])  act_s = ACT_INC;
    else if (press_s[B_DEC])  act_s = ACT_DEC;
    else                      act_s = ACT_NONE;
  end

  // Neighbouring selections with wrap, step direction and candidate value
  always_comb begin
    sel_prev_s = (sel_r == '0) ? IW'(N_ITEMS - 1) : sel_r - IW'(1);
    sel_next_s = (sel_r == IW'(N_ITEMS - 1)) ? '0 : sel_r + IW'(1);
    if (act_s == ACT_NONE) dir_up_s = hold_btn_r[B_INC];
    else                   dir_up_s = (act_s == ACT_INC);
    cur_val_s  = val_r[sel_r];
    nv_s       = step_val(cur_val_s, dir_up_s, VAL_MIN, VAL_MAX, WRAP);
    nv_chg_s   = (nv_s != cur_val_s);
    hold_lvl_s = |(lvl_s & hold_btn_r);
  end

  // Menu FSM, selection, repeat counter, value array and change strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= HIDDEN;
      visible_r    <= 1'b0;
      sel_r        <= '0;
      rep_r        <= 8'd0;
      hold_btn_r   <= '0;
      cfg_strobe_r <= 1'b0;
      cfg_idx_r    <= '0;
      for (int k = 0; k < N_ITEMS; k++) val_r[k] <= INIT_VAL;
    end else begin
      cfg_strobe_r <= 1'b0;
      if (newframe) begin
        case (state_r)
          HIDDEN: begin
            if (act_s == ACT_MENU) begin
              state_r   <= IDLE;
              visible_r <= 1'b1;
            end else begin
              state_r   <= HIDDEN;
            end
          end
          IDLE: begin
            case (act_s)
              ACT_MENU: begin
                state_r   <= HIDDEN;
                visible_r <= 1'b0;
              end
              ACT_UP:   sel_r <= sel_prev_s;
              ACT_DOWN: sel_r <= sel_next_s;
              ACT_INC, ACT_DEC: begin
                val_r[sel_r] <= nv_s;
                cfg_strobe_r <= nv_chg_s;
                cfg_idx_r    <= sel_r;
                rep_r        <= DELAY_L;
                hold_btn_r   <= (act_s == ACT_INC) ? N_BTN'(1 << B_INC) : N_BTN'(1 << B_DEC);
                state_r      <= HOLD;
              end
              default: state_r <= IDLE;
            endcase
          end
          HOLD: begin
            case (act_s)
              ACT_MENU: begin
                state_r   <= HIDDEN;
                visible_r <= 1'b0;
              end
              ACT_UP: begin
                sel_r   <= sel_prev_s;
                state_r <= IDLE;
              end
              ACT_DOWN: begin
                sel_r   <= sel_next_s;
                state_r <= IDLE;
              end
              ACT_INC, ACT_DEC: begin
                val_r[sel_r] <= nv_s;
                cfg_strobe_r <= nv_chg_s;
                cfg_idx_r    <= sel_r;
                state_r      <= IDLE;
              end
              default: begin
                if (!hold_lvl_s) begin
                  state_r <= IDLE;
                end else if (rep_r == 8'd1) begin
                  val_r[sel_r] <= nv_s;
                  cfg_strobe_r <= nv_chg_s;
                  cfg_idx_r    <= sel_r;
                  rep_r        <= RATE_L;
                end else begin
                  rep_r <= rep_r - 8'd1;
                end
              end
            endcase
          end
          default: begin
            state_r   <= HIDDEN;
            visible_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Renderer read port; indices beyond the item count read as zero
  always_comb begin
    rd_val_s = 8'h00;
    rd_hl_s  = 1'b0;
    if (32'(rd_idx) < N_ITEMS) begin
      rd_val_s = val_r[rd_idx];
      rd_hl_s  = visible_r && (rd_idx == sel_r);
    end else begin
      rd_val_s = 8'h00;
      rd_hl_s  = 1'b0;
    end
  end

  for (genvar v = 0; v < N_ITEMS; v++) begin : g_vals
    assign values[8*v +: 8] = val_r[v];
  end

  assign rd_val       = rd_val_s;
  assign rd_hl        = rd_hl_s;
  assign menu_visible = visible_r;
  assign sel_item     = sel_r;
  assign cfg_strobe   = cfg_strobe_r;
  assign cfg_idx      = cfg_idx_r;

endmodule
